// File: rtl/axi_lite_fifo_master.sv
// AXI4-Lite master that moves one wide host word as N sequential single-beat
// register writes, or assembles one wide word from N sequential register reads.
module axi_lite_fifo_master #(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int WORD_WIDTH     = 256,
  parameter int RD_BASE_ADDR   = WORD_WIDTH / AXI_DATA_WIDTH
) (
  input  logic                      i_axi_clk,
  input  logic                      i_axi_reset_n,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic                      o_axi_awvalid,
  input  logic                      i_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] o_axi_wdata,
  output logic [3:0]                o_axi_wstrb,
  output logic                      o_axi_wvalid,
  input  logic                      i_axi_wready,
  input  logic [1:0]                i_axi_bresp,
  input  logic                      i_axi_bvalid,
  output logic                      o_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_araddr,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]                i_axi_rresp,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready,
  input  logic                      i_wr_valid,
  input  logic [WORD_WIDTH-1:0]     i_wr_data,
  output logic                      o_wr_ready,
  input  logic                      i_rd_req,
  output logic                      o_rd_req_ready,
  output logic                      o_rd_valid,
  output logic [WORD_WIDTH-1:0]     o_rd_data,
  input  logic                      i_rd_ready,
  output logic                      o_busy,
  output logic                      o_err,
  input  logic                      i_err_clr
);

  localparam int N  = WORD_WIDTH / AXI_DATA_WIDTH;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RD_OUT} state_t;

  state_t                    state_q;
  logic [KW-1:0]             k_q;
  logic [WORD_WIDTH-1:0]     wr_word_q;
  logic [WORD_WIDTH-1:0]     rd_word_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic aw_done_q, w_done_q;
  logic wr_ready_q, rd_req_ready_q, rd_valid_q, err_q;

  logic [KW-1:0] k_nxt;
  logic last_beat, aw_hs, w_hs, aw_ok, w_ok, ar_hs;
  logic wr_start, rd_start, wr_beat_done, r_hs, err_set;

  assign k_nxt     = k_q + 1'b1;
  assign last_beat = (k_q == KW'(N - 1));
  assign aw_hs     = awvalid_q & i_axi_awready;
  assign w_hs      = wvalid_q & i_axi_wready;
  assign aw_ok     = aw_done_q | aw_hs;
  assign w_ok      = w_done_q | w_hs;
  assign ar_hs     = arvalid_q & i_axi_arready;
  assign wr_start  = (state_q == IDLE) & wr_ready_q & i_wr_valid;
  assign rd_start  = (state_q == IDLE) & rd_req_ready_q & i_rd_req & ~wr_start;
  // A B response is honoured in WR_ADDR once the last of AW/W completes in that same cycle.
  assign wr_beat_done = i_axi_bvalid & bready_q &
                        ((state_q == WR_RESP) | ((state_q == WR_ADDR) & aw_ok & w_ok));
  assign r_hs      = i_axi_rvalid & rready_q &
                     ((state_q == RD_DATA) | ((state_q == RD_ADDR) & ar_hs));
  assign err_set   = (wr_beat_done & (i_axi_bresp != 2'b00)) | (r_hs & (i_axi_rresp != 2'b00));

  always_ff @(posedge i_axi_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      state_q        <= IDLE;
      k_q            <= '0;
      wr_word_q      <= '0;
      rd_word_q      <= '0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      wdata_q        <= '0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      wr_ready_q     <= 1'b0;
      rd_req_ready_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      if (err_set)        err_q <= 1'b1;
      else if (i_err_clr) err_q <= 1'b0;

      if (aw_hs) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
      if (w_hs)  begin wvalid_q  <= 1'b0; w_done_q  <= 1'b1; end
      if (ar_hs) arvalid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (wr_start) begin
            state_q        <= WR_ADDR;
            k_q            <= '0;
            awaddr_q       <= '0;
            wdata_q        <= i_wr_data[WORD_WIDTH-1 -: AXI_DATA_WIDTH];
            wr_word_q      <= i_wr_data << AXI_DATA_WIDTH;
            awvalid_q      <= 1'b1;
            wvalid_q       <= 1'b1;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            bready_q       <= 1'b1;
            wr_ready_q     <= 1'b0;
            rd_req_ready_q <= 1'b0;
          end else if (rd_start) begin
            state_q        <= RD_ADDR;
            k_q            <= '0;
            araddr_q       <= AXI_ADDR_WIDTH'(RD_BASE_ADDR);
            arvalid_q      <= 1'b1;
            rready_q       <= 1'b1;
            wr_ready_q     <= 1'b0;
            rd_req_ready_q <= 1'b0;
          end else begin
            wr_ready_q     <= 1'b1;
            rd_req_ready_q <= 1'b1;
          end
        end
        WR_ADDR, WR_RESP: begin
          if (wr_beat_done) begin
            if (last_beat) begin
              state_q        <= IDLE;
              bready_q       <= 1'b0;
              wr_ready_q     <= 1'b1;
              rd_req_ready_q <= 1'b1;
            end else begin
              // The word is kept pre-shifted so the next beat is always its top slice.
              state_q   <= WR_ADDR;
              k_q       <= k_nxt;
              awaddr_q  <= AXI_ADDR_WIDTH'(k_nxt);
              wdata_q   <= wr_word_q[WORD_WIDTH-1 -: AXI_DATA_WIDTH];
              wr_word_q <= wr_word_q << AXI_DATA_WIDTH;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end
          end else if ((state_q == WR_ADDR) && aw_ok && w_ok) begin
            state_q <= WR_RESP;
          end
        end
        RD_ADDR, RD_DATA: begin
          if (r_hs) begin
            // Shifting in from the bottom leaves beat 0 in the top slice after N beats.
            rd_word_q <= (rd_word_q << AXI_DATA_WIDTH) | WORD_WIDTH'(i_axi_rdata);
            if (last_beat) begin
              state_q    <= RD_OUT;
              rready_q   <= 1'b0;
              rd_valid_q <= 1'b1;
            end else begin
              state_q   <= RD_ADDR;
              k_q       <= k_nxt;
              araddr_q  <= AXI_ADDR_WIDTH'(RD_BASE_ADDR) + AXI_ADDR_WIDTH'(k_nxt);
              arvalid_q <= 1'b1;
            end
          end else if ((state_q == RD_ADDR) && ar_hs) begin
            state_q <= RD_DATA;
          end
        end
        RD_OUT: begin
          if (i_rd_ready) begin
            state_q        <= IDLE;
            rd_valid_q     <= 1'b0;
            wr_ready_q     <= 1'b1;
            rd_req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_axi_awaddr   = awaddr_q;
  assign o_axi_awvalid  = awvalid_q;
  assign o_axi_wdata    = wdata_q;
  assign o_axi_wstrb    = wvalid_q ? 4'hF : 4'h0;
  assign o_axi_wvalid   = wvalid_q;
  assign o_axi_bready   = bready_q;
  assign o_axi_araddr   = araddr_q;
  assign o_axi_arvalid  = arvalid_q;
  assign o_axi_rready   = rready_q;
  assign o_wr_ready     = wr_ready_q;
  assign o_rd_req_ready = rd_req_ready_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_rd_data      = rd_word_q;
  assign o_busy         = (state_q != IDLE);
  assign o_err          = err_q;

endmodule

// File: tb/tb_axi_lite_fifo_master.sv
// Bench for axi_lite_fifo_master: behavioural AXI-Lite slave with tunable
// latencies plus a word-level expectation model for writes and reads.
module tb_axi_lite_fifo_master;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   o_axi_awaddr, o_axi_araddr;
  logic [31:0]  o_axi_wdata;
  logic [3:0]   o_axi_wstrb;
  logic         o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready;
  logic         awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0]   bresp = 0, rresp = 0;
  logic [31:0]  rdata = 0;
  logic         i_wr_valid = 0, i_rd_req = 0, i_rd_ready = 0, i_err_clr = 0;
  logic [255:0] i_wr_data = '0;
  logic         o_wr_ready, o_rd_req_ready, o_rd_valid, o_busy, o_err;
  logic [255:0] o_rd_data;

  axi_lite_fifo_master #(.AXI_ADDR_WIDTH(8), .AXI_DATA_WIDTH(32), .WORD_WIDTH(256), .RD_BASE_ADDR(8)) dut (
    .i_axi_clk(clk), .i_axi_reset_n(rst_n),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(wready),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(o_axi_bready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid), .o_axi_rready(o_axi_rready),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .i_rd_req(i_rd_req), .o_rd_req_ready(o_rd_req_ready),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
    .o_busy(o_busy), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  typedef struct packed { logic [7:0] addr; logic [31:0] data; logic [3:0] strb; } wbeat_t;
  wbeat_t      wr_log[$];
  logic [7:0]  rd_addr_log[$];
  logic [31:0] rmem [256];

  // Configuration (written by the stimulus only)
  int cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0, cfg_r_lat = 0;
  bit cfg_b_early = 0, rand_lat = 0;
  int err_beat = -1, rerr_addr = -1;

  // Slave-private state
  int rnd_aw = 0, rnd_w = 0, rnd_ar = 0, rnd_r = 0;
  bit rnd_early = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_idx = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0;
  logic [7:0]  cur_addr = 0, cur_raddr = 0;
  logic [31:0] cur_data = 0;
  logic [3:0]  cur_strb = 0;

  int aw_lat, w_lat, ar_lat, r_lat;
  bit b_early;
  always_comb begin
    aw_lat  = rand_lat ? rnd_aw : cfg_aw_lat;
    w_lat   = rand_lat ? rnd_w : cfg_w_lat;
    ar_lat  = rand_lat ? rnd_ar : cfg_ar_lat;
    r_lat   = rand_lat ? rnd_r : cfg_r_lat;
    b_early = rand_lat ? rnd_early : cfg_b_early;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_idx = 0;
    end else begin
      if (awready) begin awready = 0; aw_got = 1; end
      if (wready)  begin wready = 0;  w_got = 1;  end
      if (bvalid) begin
        bvalid = 0;
        wr_log.push_back({cur_addr, cur_data, cur_strb});
        aw_got = 0; w_got = 0;
        b_idx = (b_idx + 1) % N;
        rnd_aw = $urandom_range(0, 3); rnd_w = $urandom_range(0, 3); rnd_early = 1'($urandom_range(0, 1));
      end
      if (o_axi_awvalid && !aw_got && !awready) begin
        if (aw_cnt >= aw_lat) begin awready = 1; cur_addr = o_axi_awaddr; aw_cnt = 0; end
        else aw_cnt++;
      end
      if (o_axi_wvalid && !w_got && !wready) begin
        if (w_cnt >= w_lat) begin wready = 1; cur_data = o_axi_wdata; cur_strb = o_axi_wstrb; w_cnt = 0; end
        else w_cnt++;
      end
      if (!bvalid && o_axi_bready &&
          (b_early ? ((aw_got || awready) && (w_got || wready)) : (aw_got && w_got))) begin
        bvalid = 1;
        bresp  = (b_idx == err_beat) ? 2'b10 : 2'b00;
      end
      if (arready) begin arready = 0; ar_got = 1; end
      if (rvalid) rvalid = 0;
      if (o_axi_arvalid && !ar_got && !arready) begin
        if (ar_cnt >= ar_lat) begin
          arready = 1; cur_raddr = o_axi_araddr; rd_addr_log.push_back(o_axi_araddr); ar_cnt = 0;
        end else ar_cnt++;
      end
      if (ar_got && !rvalid && o_axi_rready) begin
        if (r_cnt >= r_lat) begin
          rvalid = 1; rdata = rmem[cur_raddr];
          rresp = (int'(cur_raddr) == rerr_addr) ? 2'b10 : 2'b00;
          ar_got = 0; r_cnt = 0;
          rnd_ar = $urandom_range(0, 3); rnd_r = $urandom_range(0, 3);
        end else r_cnt++;
      end
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input logic [255:0] w, input string tag);
    int cyc, viol;
    bit rdy;
    logic [255:0] sh;
    wr_log.delete();
    i_wr_valid = 1; i_wr_data = w;
    cyc = 0;
    do begin rdy = o_wr_ready; tick(); cyc++; end while (!rdy && cyc < 50);
    i_wr_valid = 0;
    viol = 0; cyc = 0;
    while ((o_busy || wr_log.size() < N) && cyc < 400) begin
      if (o_wr_ready && wr_log.size() < N) viol++;
      if (aw_got && o_axi_awvalid) viol++;
      if (aw_got && !w_got && !o_axi_wvalid) viol++;
      if (o_axi_arvalid) viol++;
      tick(); cyc++;
    end
    chk({tag, " done"}, 256'(cyc < 400), 256'(1));
    chk({tag, " beats"}, 256'(wr_log.size()), 256'(N));
    for (int j = 0; j < N && j < wr_log.size(); j++) begin
      sh = w >> (32 * (N - 1 - j));
      chk($sformatf("%s beat%0d", tag, j), 256'(wr_log[j]), 256'({8'(j), sh[31:0], 4'hF}));
    end
    chk({tag, " proto"}, 256'(viol), 256'(0));
  endtask

  task automatic read_word(input string tag, input bit hold);
    int cyc, viol;
    logic [255:0] exp;
    rd_addr_log.delete();
    exp = '0;
    for (int j = 0; j < N; j++) exp = (exp << 32) | 256'(rmem[8 + j]);
    i_rd_req = 1;
    cyc = 0;
    while (!o_axi_arvalid && cyc < 50) begin tick(); cyc++; end
    i_rd_req = 0;
    viol = 0;
    while (!o_rd_valid && cyc < 600) begin
      if (o_axi_awvalid || o_axi_wvalid) viol++;
      tick(); cyc++;
    end
    chk({tag, " done"}, 256'(cyc < 600), 256'(1));
    chk({tag, " data"}, o_rd_data, exp);
    viol += (rd_addr_log.size() != N) ? 1 : 0;
    for (int j = 0; j < rd_addr_log.size(); j++) if (rd_addr_log[j] != 8'(8 + j)) viol++;
    chk({tag, " araddr/proto"}, 256'(viol), 256'(0));
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        tick();
        chk($sformatf("%s hold%0d", tag, c), {o_rd_valid, o_rd_data}, {1'b1, exp});
      end
    end
    i_rd_ready = 1;
    tick();
    i_rd_ready = 0;
    chk({tag, " release"}, 256'({o_rd_valid, o_busy, o_rd_req_ready}), 256'(3'b001));
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w = '0;
    for (int j = 0; j < N; j++) w = (w << 32) | 256'($urandom());
    return w;
  endfunction

  initial begin
    int cyc;
    for (int a = 0; a < 256; a++) rmem[a] = $urandom();

    tick(); tick();
    chk("reset ctl", 256'({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready,
         o_wr_ready, o_rd_req_ready, o_rd_valid, o_busy, o_err, o_axi_wstrb}), 256'(0));
    chk("reset addr/data", 256'({o_axi_awaddr, o_axi_araddr, o_axi_wdata}), 256'(0));
    chk("reset rd_data", o_rd_data, 256'(0));
    rst_n = 1;
    tick();
    chk("ready after reset", 256'({o_wr_ready, o_rd_req_ready, o_busy}), 256'(3'b110));

    write_word(256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008, "wr_seq");
    chk("wr_seq err", 256'(o_err), 256'(0));

    for (int j = 0; j < N; j++) rmem[8 + j] = 32'hA0 + 32'(j);
    read_word("rd_a0", 1'b1);

    cfg_aw_lat = 0; cfg_w_lat = 3; cfg_b_early = 1;
    write_word(rand_word(), "wr_aw_first");

    cfg_aw_lat = 1; cfg_w_lat = 1; cfg_b_early = 0; cfg_ar_lat = 1; cfg_r_lat = 1;
    i_rd_req = 1;
    write_word(rand_word(), "both_wr");
    read_word("both_rd", 1'b0);
    chk("both err", 256'(o_err), 256'(0));

    err_beat = 3;
    write_word(rand_word(), "wr_err3");
    chk("err set", 256'(o_err), 256'(1));
    i_err_clr = 1; tick(); i_err_clr = 0;
    chk("err clr", 256'(o_err), 256'(0));

    err_beat = 7; i_err_clr = 1;
    write_word(rand_word(), "wr_err_vs_clr");
    i_err_clr = 0;
    chk("err set wins", 256'(o_err), 256'(1));
    i_err_clr = 1; tick(); i_err_clr = 0;
    err_beat = -1;

    rerr_addr = 13;
    read_word("rd_rresp", 1'b0);
    chk("rresp err", 256'(o_err), 256'(1));
    i_err_clr = 1; tick(); i_err_clr = 0;
    chk("rresp err clr", 256'(o_err), 256'(0));
    rerr_addr = -1;

    rand_lat = 1;
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < N; j++) rmem[8 + j] = $urandom();
      write_word(rand_word(), $sformatf("rnd_wr%0d", it));
      read_word($sformatf("rnd_rd%0d", it), 1'($urandom_range(0, 1)));
    end
    rand_lat = 0;
    chk("rnd err", 256'(o_err), 256'(0));

    cfg_ar_lat = 6; cfg_r_lat = 0;
    i_rd_req = 1;
    cyc = 0;
    while (!o_axi_arvalid && cyc < 50) begin tick(); cyc++; end
    i_rd_req = 0;
    while (!(o_axi_arvalid && o_axi_araddr == 8'd12) && cyc < 400) begin tick(); cyc++; end
    chk("beat4 reached", 256'({o_axi_arvalid, o_axi_araddr}), 256'({1'b1, 8'd12}));
    #2 rst_n = 0;
    #1;
    chk("async rst ctl", 256'({o_axi_arvalid, o_axi_rready, o_busy, o_wr_ready, o_rd_req_ready, o_rd_valid}), 256'(0));
    chk("async rst addr", 256'({o_axi_araddr, o_rd_data}), 256'(0));
    tick(); tick();
    rst_n = 1;
    cfg_ar_lat = 0;
    tick();
    chk("ready after rst2", 256'({o_wr_ready, o_rd_req_ready, o_busy}), 256'(3'b110));
    for (int j = 0; j < N; j++) rmem[8 + j] = $urandom();
    read_word("rd_after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1);
  end

endmodule
